// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows stage with ping-pong block buffers (1 byte/cycle sustained).
// Optional feature: define INV_SHIFT_ROWS_BYPASS_EN to add bypass_in (per-block natural-order pass-through).
module inv_shift_rows_stream #(
    parameter int N  = 128,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
`ifdef INV_SHIFT_ROWS_BYPASS_EN
    input  logic          bypass_in,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_last
);

    if (N != 128 || BW != 8) begin : g_bad_params
        $error("inv_shift_rows_stream supports only N=128 and BW=8");
    end

    logic [BW-1:0] mem [2][16];
    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [3:0]    wr_cnt;
    logic [3:0]    rd_cnt;
    logic          in_fire;
    logic          out_fire;
    logic [1:0]    src_col;
    logic [3:0]    src_idx;
    logic          rd_bypass;

    assign in_ready = !full[wr_sel];
    assign in_fire  = in_valid && in_ready;
    assign out_valid = full[rd_sel];
    assign out_fire  = out_valid && out_ready;

    // Row r of output column c comes from input column (c - r) mod 4, same row.
    assign src_col = rd_cnt[3:2] - rd_cnt[1:0];

`ifdef INV_SHIFT_ROWS_BYPASS_EN
    logic [1:0] bypass_flag;

    always_ff @(posedge clk) begin
        if (in_fire && wr_cnt == 4'd0) begin
            bypass_flag[wr_sel] <= bypass_in;
        end
    end

    assign rd_bypass = bypass_flag[rd_sel];
`else
    assign rd_bypass = 1'b0;
`endif

    assign src_idx  = rd_bypass ? rd_cnt : {src_col, rd_cnt[1:0]};
    assign out_data = out_valid ? mem[rd_sel][src_idx] : '0;
    assign out_last = out_valid && (rd_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_sel][wr_cnt] <= in_data;
        end
    end

    // Fill and drain always touch different buffers, so both flag updates can land in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_cnt <= 4'd0;
            rd_cnt <= 4'd0;
        end else begin
            if (in_fire) begin
                wr_cnt <= wr_cnt + 4'd1;
                if (wr_cnt == 4'd15) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                end
            end
            if (out_fire) begin
                rd_cnt <= rd_cnt + 4'd1;
                if (rd_cnt == 4'd15) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed self-checking bench for inv_shift_rows_stream (bypass steps only when INV_SHIFT_ROWS_BYPASS_EN is defined).
module tb_inv_shift_rows_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
`ifdef INV_SHIFT_ROWS_BYPASS_EN
    logic       bypass_in;
`endif

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    bit         rand_mode = 1'b0;
    bit         stalled   = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    logic [7:0] blk     [16];
    logic [7:0] exp_blk [16];

    inv_shift_rows_stream dut (
        .clk       (clk),
        .rst       (rst),
`ifdef INV_SHIFT_ROWS_BYPASS_EN
        .bypass_in (bypass_in),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int src_of(input int k);
        int c = k / 4;
        int r = k % 4;
        return 4 * ((c - r + 4) % 4) + r;
    endfunction

    task automatic enqueue_const(input logic [7:0] e [16]);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(e[k]);
            exp_last_q.push_back(k == 15);
        end
    endtask

    task automatic enqueue_model(input logic [7:0] b [16], input bit natural);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(natural ? b[k] : b[src_of(k)]);
            exp_last_q.push_back(k == 15);
        end
    endtask

    // Checks output side before the edge, then advances to 1 time unit after it.
    task automatic tick();
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_last", out_last, held_last);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_valid, 0);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
                check("out_last", out_last, exp_last_q.pop_front());
            end
        end
        stalled   = out_valid && !out_ready;
        held_data = out_data;
        held_last = out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        int guard = 0;
        if (rand_mode) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 2000) begin
            tick();
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic push_block(input logic [7:0] b [16]);
        for (int k = 0; k < 16; k++) push_byte(b[k]);
    endtask

    task automatic drain();
        int guard = 0;
        if (!rand_mode) out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 5000) begin
            tick();
            guard++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef INV_SHIFT_ROWS_BYPASS_EN
        bypass_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);

        // Counting block and its first-byte latency
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) blk[k] = 8'(k);
        exp_blk = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                    8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
        enqueue_const(exp_blk);
        for (int k = 0; k < 15; k++) push_byte(blk[k]);
        check("latency_not_early", out_valid, 0);
        push_byte(blk[15]);
        check("latency_out_valid", out_valid, 1);
        check("latency_first_data", out_data, 8'h00);
        drain();

        // FIPS-197 round 1 state after ShiftRows goes back to SubBytes order
        blk     = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                    8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
        exp_blk = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                    8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
        enqueue_const(exp_blk);
        push_block(blk);
        drain();

        // Three blocks against a stalled sink: both buffers fill, then drain
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 16; k++) blk[k] = 8'(8'h40 + 16 * b + k);
            enqueue_model(blk, 1'b0);
        end
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 16; k++) blk[k] = 8'(8'h40 + 16 * b + k);
            push_block(blk);
        end
        check("full_in_ready_low", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        tick();
        tick();
        out_ready = 1'b1;
        repeat (15) tick();
        check("drain_last_flag", out_last, 1);
        check("no_bypass_in_ready", in_ready, 0);
        tick();
        check("in_ready_reopen", in_ready, 1);
        for (int k = 0; k < 16; k++) blk[k] = 8'(8'h60 + k);
        push_block(blk);
        drain();

        // Reset while one block drains and the next is partly filled
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) blk[k] = 8'(8'h70 + k);
        enqueue_model(blk, 1'b0);
        push_block(blk);
        for (int k = 0; k < 7; k++) push_byte(8'(8'h80 + k));
        out_ready = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        exp_last_q.delete();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        stalled = 1'b0;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_out_last", out_last, 0);
        check("rst2_out_data", out_data, 0);
        check("rst2_in_ready", in_ready, 1);
        for (int k = 0; k < 16; k++) blk[k] = 8'(8'h90 + k);
        enqueue_model(blk, 1'b0);
        push_block(blk);
        drain();

        // Random gaps on both sides
        rand_mode = 1'b1;
        for (int b = 0; b < 200; b++) begin
            for (int k = 0; k < 16; k++) blk[k] = 8'($urandom_range(0, 255));
            enqueue_model(blk, 1'b0);
            push_block(blk);
        end
        drain();
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();

`ifdef INV_SHIFT_ROWS_BYPASS_EN
        for (int k = 0; k < 16; k++) blk[k] = 8'(k);
        bypass_in = 1'b1;
        enqueue_model(blk, 1'b1);
        push_block(blk);
        bypass_in = 1'b0;
        exp_blk = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                    8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
        enqueue_const(exp_blk);
        push_block(blk);
        drain();
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
